// File: rtl/serial_crc_checker.sv
// Serial CRC checker for g(y) = 1 + y + y^8 + y^9: divides a 19-bit serial codeword
// (10 data bits MSB first, then 9 CRC bits) and reports the recovered data and frame status.
module serial_crc_checker #(
  parameter int                 DATA_W = 10,
  parameter int                 CRC_W  = 9,
  parameter logic [CRC_W-1:0]   POLY   = 9'h103
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] data_out,
  output logic              crc_ok,
  output logic              crc_err,
  output logic              frame_done,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W + CRC_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W + CRC_W - 1);
  localparam logic [CNT_W-1:0]  DATA_CNT = CNT_W'(DATA_W);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CRC_W-1:0]    r_lfsr;
  logic [CRC_W-1:0]    w_lfsr_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_data_sr;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_crc_ok;
  logic                r_crc_err;
  logic                r_frame_done;
  logic                w_start;
  logic                w_step;
  logic                w_last;

  // One division step; POLY[0] = 1 makes the new r[0] equal to the feedback bit.
  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] r, input logic b);
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return {r[CRC_W-2:0], 1'b0} ^ (POLY & {CRC_W{fb}});
  endfunction

  // A sof restarts the division from an all-zero register.
  assign w_lfsr_next = lfsr_step(w_start ? '0 : r_lfsr, bit_in);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bit_valid && sof) begin
          w_start      = 1'b1;
          w_state_next = RECV;
        end
      end
      RECV: begin
        if (bit_valid) begin
          if (sof) begin
            w_start = 1'b1;
          end else begin
            w_step = 1'b1;
            if (r_cnt == LAST_CNT) begin
              w_last       = 1'b1;
              w_state_next = IDLE;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= '0;
      r_cnt        <= '0;
      r_data_sr    <= '0;
      r_data_out   <= '0;
      r_crc_ok     <= 1'b0;
      r_crc_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      if (w_start) begin
        r_lfsr    <= w_lfsr_next;
        r_cnt     <= CNT_W'(1);
        r_data_sr <= {{(DATA_W-1){1'b0}}, bit_in};
        r_crc_ok  <= 1'b0;
        r_crc_err <= 1'b0;
      end else if (w_step) begin
        r_lfsr <= w_lfsr_next;
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        if (r_cnt < DATA_CNT) r_data_sr <= {r_data_sr[DATA_W-2:0], bit_in};
        if (w_last) begin
          r_data_out <= r_data_sr;
          r_crc_ok   <= (w_lfsr_next == '0);
          r_crc_err  <= (w_lfsr_next != '0);
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign crc_ok     = r_crc_ok;
  assign crc_err    = r_crc_err;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == RECV);

endmodule
